ycr1_wb_burst_mst: RTL and testbench
====================================

YCR1_WB_BURST_MST -- requirements
Module: ycr1_wb_burst_mst

Interface
REQ-001 SHALL have parameter: YCR1_WB_WIDTH, 32, Wishbone data/address width (only 32 supported).
REQ-002 SHALL have one clock and an asynchronous active-low reset; ports (name direction width meaning):
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  async active-low reset.
- cmd_req_i  in  1  burst request, held until cmd_ack_o.
- cmd_we_i  in  1  1=write burst, 0=read burst.
- cmd_adr_i  in  32  burst base byte address; [6:0] ignored.
- cmd_sel_i  in  4  byte enables, applied to every beat.
- cmd_bl_i  in  8  burst length in beats, legal 1..32.
- cmd_ack_o  out  1  one-cycle pulse, command accepted.
- wdata_beat_o  out  5  index of the write beat currently driven.
- wdata_i  in  32  write data for wdata_beat_o, used combinationally.
- rdata_vld_o  out  1  read beat valid.
- rdata_o  out  32  read beat data.
- rdata_last_o  out  1  final read beat, qualified by rdata_vld_o.
- done_o  out  1  one-cycle pulse, burst finished without error.
- err_o  out  1  one-cycle pulse, burst rejected or aborted.
- wbd_stb_o, wbd_we_o  out  1  Wishbone strobe / write enable.
- wbd_adr_o  out  32  current beat address.
- wbd_dat_o  out  32  write data.
- wbd_sel_o  out  4  byte select.
- wbd_bl_o  out  8  burst length.
- wbd_dat_i  in  32  read data.
- wbd_ack_i, wbd_lack_i, wbd_err_i  in  1  beat ack, last-beat ack, error.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, GAP.
REQ-004 IDLE: wbd_stb_o=0; on cmd_req_i=1 with 1<=cmd_bl_i<=32, SHALL latch we/adr[31:7]/sel/bl, pulse cmd_ack_o, and enter BUSY; wbd_stb_o=1 the next cycle (1-cycle latency).
REQ-005 IDLE: cmd_req_i=1 with cmd_bl_i=0 or >32 SHALL pulse cmd_ack_o and err_o in the same cycle, stay in IDLE, issue no bus cycle.
REQ-006 BUSY: wbd_stb_o, wbd_we_o, wbd_sel_o, wbd_bl_o SHALL be held constant; wbd_adr_o = {base[31:7], beat[4:0], 2'b00}.
REQ-007 Beat counter (5 bits, reset 0 at burst start) SHALL increment on each posedge with wbd_stb_o=1 and wbd_ack_i=1; wdata_beat_o = beat; wbd_dat_o = wdata_i while writing, 0 otherwise.
REQ-008 Read: each acked beat SHALL produce rdata_vld_o=1 and rdata_o=wbd_dat_i registered, one cycle after the ack edge.
REQ-009 Normal end: ack with wbd_lack_i=1 on beat index bl-1 SHALL deassert wbd_stb_o next cycle, pulse done_o, assert rdata_last_o with the final read beat, and enter GAP.
REQ-010 Ack on beat bl-1 without lack SHALL still end the burst as REQ-009 (count-terminated).
REQ-011 wbd_lack_i before beat bl-1 SHALL end the burst as REQ-009 but pulse err_o instead of done_o; rdata_last_o still marks that beat.
REQ-012 wbd_err_i=1 while wbd_stb_o=1 SHALL abort: stb low next cycle, err_o pulse, no further rdata_vld_o, enter GAP; err_i takes priority over a simultaneous ack.
REQ-013 GAP: wbd_stb_o=0 for exactly one cycle, so the responder sees a fresh stb rising edge; then IDLE; cmd_req_i ignored in GAP.
REQ-014 cmd_req_i in BUSY/GAP SHALL be ignored (no cmd_ack_o); acks with wbd_stb_o=0 SHALL be ignored.
REQ-015 done_o and err_o SHALL never pulse in the same cycle.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, beat=0, and all outputs 0 (wbd_stb_o=0 immediately, including mid-burst); the in-flight burst is discarded with no done_o/err_o.

Configuration
REQ-017 With YCR1_WB_MST_TIMEOUT_EN defined: 8-bit counter, cleared on burst start and each ack, increments each BUSY cycle without ack; at 255 SHALL abort as REQ-012 (err_o pulse). Without the macro: no counter, BUSY waits indefinitely for ack.

Verification
REQ-018 Read bl=8, adr=0x0000_1080, responder acks every cycle with lack on 8th -> adr 0x1080..0x109C, 8 rdata_vld_o beats, rdata_last_o on 8th, done_o once, stb low 1 cycle then IDLE.
REQ-019 Write bl=4, sel=0xF, wdata_i=0xA0+beat, random ack stalls -> responder memory holds 0xA0..0xA3 at consecutive words; done_o once.
REQ-020 cmd_bl_i=0 and cmd_bl_i=33 -> cmd_ack_o+err_o same cycle, wbd_stb_o stays 0.
REQ-021 Read bl=16, wbd_err_i on beat 5 together with ack -> err_o, stb low next cycle, exactly 5 rdata_vld_o beats.
REQ-022 rst_n low during beat 3 of bl=8 burst -> wbd_stb_o=0 asynchronously, no done_o/err_o; next command runs normally.
REQ-023 With YCR1_WB_MST_TIMEOUT_EN: responder never acks -> err_o exactly 255 BUSY cycles after stb rise; without macro stb stays high for 1000 cycles.

Source files
------------

// File: rtl/ycr1_wb_burst_mst_if.sv
// Wishbone burst bus between ycr1_wb_burst_mst and its responder.
interface ycr1_wb_burst_mst_if #(
  parameter int unsigned YCR1_WB_WIDTH = 32
);
  logic                     wbd_stb_o;
  logic                     wbd_we_o;
  logic [YCR1_WB_WIDTH-1:0] wbd_adr_o;
  logic [YCR1_WB_WIDTH-1:0] wbd_dat_o;
  logic [3:0]               wbd_sel_o;
  logic [7:0]               wbd_bl_o;
  logic [YCR1_WB_WIDTH-1:0] wbd_dat_i;
  logic                     wbd_ack_i;
  logic                     wbd_lack_i;
  logic                     wbd_err_i;

  modport master (
    output wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_bl_o,
    input  wbd_dat_i, wbd_ack_i, wbd_lack_i, wbd_err_i
  );

  modport slave (
    input  wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_bl_o,
    output wbd_dat_i, wbd_ack_i, wbd_lack_i, wbd_err_i
  );
endinterface

// File: rtl/ycr1_wb_burst_mst.sv
// Wishbone burst master: one command -> up to 32 beats in a 128-byte window.
// Define YCR1_WB_MST_TIMEOUT_EN to abort bursts whose responder stops acking.
module ycr1_wb_burst_mst #(
  parameter int unsigned YCR1_WB_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_req_i,
  input  logic                     cmd_we_i,
  input  logic [YCR1_WB_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]               cmd_sel_i,
  input  logic [7:0]               cmd_bl_i,
  output logic                     cmd_ack_o,
  output logic [4:0]               wdata_beat_o,
  input  logic [YCR1_WB_WIDTH-1:0] wdata_i,
  output logic                     rdata_vld_o,
  output logic [YCR1_WB_WIDTH-1:0] rdata_o,
  output logic                     rdata_last_o,
  output logic                     done_o,
  output logic                     err_o,
  ycr1_wb_burst_mst_if.master      wbd
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_e;

  state_e                   state_q, state_d;
  logic                     we_q, we_d;
  logic [24:0]              base_q, base_d;
  logic [3:0]               sel_q, sel_d;
  logic [7:0]               bl_q, bl_d;
  logic [4:0]               beat_q, beat_d;
  logic                     rvld_q, rvld_d;
  logic [YCR1_WB_WIDTH-1:0] rdata_q, rdata_d;
  logic                     rlast_q, rlast_d;
  logic                     done_q, done_d;
  logic                     berr_q, berr_d;
  logic                     acc_c, rej_c;
  logic                     bl_ok, last_beat, busy, to_hit;
  logic                     unused_adr;

  assign unused_adr = ^cmd_adr_i[6:0];
  assign bl_ok      = (cmd_bl_i != 8'd0) && (cmd_bl_i <= 8'd32);
  assign last_beat  = ({3'b000, beat_q} == (bl_q - 8'd1));
  assign busy       = (state_q == ST_BUSY);

`ifdef YCR1_WB_MST_TIMEOUT_EN
  logic [7:0] to_q, to_d;

  always_comb begin
    to_d   = to_q;
    to_hit = 1'b0;
    if (state_q == ST_IDLE) begin
      to_d = '0;
    end else if (busy) begin
      if (wbd.wbd_ack_i) begin
        to_d = '0;
      end else begin
        to_d   = to_q + 8'd1;
        to_hit = (to_d == 8'hFF);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    base_d  = base_q;
    sel_d   = sel_q;
    bl_d    = bl_q;
    beat_d  = beat_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    rlast_d = 1'b0;
    done_d  = 1'b0;
    berr_d  = 1'b0;
    acc_c   = 1'b0;
    rej_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_req_i) begin
          acc_c = 1'b1;
          if (bl_ok) begin
            we_d    = cmd_we_i;
            base_d  = cmd_adr_i[31:7];
            sel_d   = cmd_sel_i;
            bl_d    = cmd_bl_i;
            beat_d  = '0;
            state_d = ST_BUSY;
          end else begin
            rej_c = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // Error (or timeout) wins over any ack presented in the same cycle.
        if (wbd.wbd_err_i || to_hit) begin
          berr_d  = 1'b1;
          state_d = ST_GAP;
        end else if (wbd.wbd_ack_i) begin
          beat_d = beat_q + 5'd1;
          if (!we_q) begin
            rvld_d  = 1'b1;
            rdata_d = wbd.wbd_dat_i;
          end
          if (last_beat || wbd.wbd_lack_i) begin
            rlast_d = ~we_q;
            done_d  = last_beat;
            berr_d  = ~last_beat;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      base_q  <= '0;
      sel_q   <= '0;
      bl_q    <= '0;
      beat_q  <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
      done_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      base_q  <= base_d;
      sel_q   <= sel_d;
      bl_q    <= bl_d;
      beat_q  <= beat_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      rlast_q <= rlast_d;
      done_q  <= done_d;
      berr_q  <= berr_d;
    end
  end

  // Accept/reject is answered in the request cycle; rst_n masks it while held in reset.
  assign cmd_ack_o    = acc_c & rst_n;
  assign err_o        = berr_q | (rej_c & rst_n);
  assign done_o       = done_q;
  assign rdata_vld_o  = rvld_q;
  assign rdata_o      = rdata_q;
  assign rdata_last_o = rlast_q;
  assign wdata_beat_o = beat_q;

  assign wbd.wbd_stb_o = busy;
  assign wbd.wbd_we_o  = busy & we_q;
  assign wbd.wbd_adr_o = busy ? {base_q, beat_q, 2'b00} : '0;
  assign wbd.wbd_dat_o = (busy && we_q) ? wdata_i : '0;
  assign wbd.wbd_sel_o = busy ? sel_q : '0;
  assign wbd.wbd_bl_o  = busy ? bl_q : '0;

endmodule

// File: tb/tb_ycr1_wb_burst_mst.sv
// Directed bench for ycr1_wb_burst_mst: vector table of bursts plus reset/back-to-back/no-ack sequences.
`timescale 1ns/1ps
module tb_ycr1_wb_burst_mst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_req_i = 1'b0;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic [7:0]  cmd_bl_i = '0;
  logic        cmd_ack_o;
  logic [4:0]  wdata_beat_o;
  logic [31:0] wdata_i;
  logic        rdata_vld_o;
  logic [31:0] rdata_o;
  logic        rdata_last_o, done_o, err_o;

  always #5 clk = ~clk;

  ycr1_wb_burst_mst_if #(.YCR1_WB_WIDTH(32)) bus ();

  ycr1_wb_burst_mst #(.YCR1_WB_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_req_i    (cmd_req_i),
    .cmd_we_i     (cmd_we_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_sel_i    (cmd_sel_i),
    .cmd_bl_i     (cmd_bl_i),
    .cmd_ack_o    (cmd_ack_o),
    .wdata_beat_o (wdata_beat_o),
    .wdata_i      (wdata_i),
    .rdata_vld_o  (rdata_vld_o),
    .rdata_o      (rdata_o),
    .rdata_last_o (rdata_last_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .wbd          (bus)
  );

  assign wdata_i       = 32'hA0 + {27'd0, wdata_beat_o};
  assign bus.wbd_dat_i = {16'hD00D, bus.wbd_adr_o[15:0]};

  // Responder configuration, written only by the test sequence.
  logic        cfg_we = 1'b0, cfg_stall = 1'b0, cfg_silent = 1'b0;
  logic [31:0] cfg_adr = '0;
  logic [3:0]  cfg_sel = '0;
  logic [7:0]  cfg_bl = '0;
  int          cfg_lack = -1, cfg_err = -1;

  // Observation state, written only by the responder/monitor block.
  int unsigned rsp_beat = 0;
  int          vld_cnt = 0, last_at = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int          beats = 0, bus_bad = 0, rd_bad = 0, stb_cyc = 0;
  logic [31:0] rd_exp[$];
  logic [31:0] mem[32];

  always @(negedge clk) begin : mon
    logic [31:0] exp_adr;
    logic        go;
    if (cmd_ack_o) begin
      vld_cnt = 0; last_at = 0; done_cnt = 0; err_cnt = 0;
      beats = 0; bus_bad = 0; rd_bad = 0; stb_cyc = 0;
      rd_exp.delete();
      for (int i = 0; i < 32; i++) mem[i] = '0;
    end
    if (rdata_vld_o) begin
      vld_cnt++;
      if (rdata_last_o) last_at = vld_cnt;
      if (rd_exp.size() == 0) rd_bad++;
      else if (rd_exp.pop_front() != rdata_o) rd_bad++;
    end
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (done_o && err_o) both_cnt++;
    if (bus.wbd_stb_o) begin
      stb_cyc++;
      exp_adr = {cfg_adr[31:7], rsp_beat[4:0], 2'b00};
      if (bus.wbd_adr_o != exp_adr || bus.wbd_we_o != cfg_we || bus.wbd_sel_o != cfg_sel ||
          bus.wbd_bl_o != cfg_bl || (!cfg_we && bus.wbd_dat_o != 32'd0)) bus_bad++;
      go = !cfg_silent && (!cfg_stall || $urandom_range(0, 2) != 0);
      bus.wbd_ack_i  = go;
      bus.wbd_lack_i = go && (int'(rsp_beat) == cfg_lack);
      bus.wbd_err_i  = go && (int'(rsp_beat) == cfg_err);
      if (go && !bus.wbd_err_i) begin
        beats++;
        if (cfg_we) mem[rsp_beat[4:0]] = bus.wbd_dat_o;
        else        rd_exp.push_back({16'hD00D, exp_adr[15:0]});
        rsp_beat++;
      end
    end else begin
      bus.wbd_ack_i  = 1'b0;
      bus.wbd_lack_i = 1'b0;
      bus.wbd_err_i  = 1'b0;
      rsp_beat       = 0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [8*12-1:0] name;
    logic            we;
    logic [31:0]     adr;
    logic [3:0]      sel;
    logic [7:0]      bl;
    int              lack_beat;
    int              err_beat;
    logic            stall;
    logic            exp_rej;
    int              exp_done;
    int              exp_err;
    int              exp_vld;
    int              exp_last;
    int              exp_beats;
  } vec_t;

  vec_t vecs[10];

  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [7:0] bl, output logic seen, output logic ack_err);
    seen = 1'b0;
    ack_err = 1'b0;
    @(posedge clk); #1;
    cmd_req_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_bl_i = bl;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (cmd_ack_o) begin seen = 1'b1; ack_err = err_o; end
    end
    @(posedge clk); #1;
    cmd_req_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic seen, ack_err, fin;
    int   mem_bad;
    string nm;
    nm = $sformatf("%0s", v.name);
    cfg_we = v.we; cfg_adr = v.adr; cfg_sel = v.sel; cfg_bl = v.bl;
    cfg_lack = v.lack_beat; cfg_err = v.err_beat; cfg_stall = v.stall; cfg_silent = 1'b0;
    issue(v.we, v.adr, v.sel, v.bl, seen, ack_err);
    chk({nm, ".cmd_ack"}, seen, 1);
    chk({nm, ".err_with_ack"}, ack_err, v.exp_rej);
    fin = v.exp_rej;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      if (done_o || err_o) fin = 1'b1;
    end
    chk({nm, ".burst_end"}, fin, 1);
    repeat (3) @(negedge clk);
    #1;
    chk({nm, ".done_cnt"}, done_cnt, v.exp_done);
    chk({nm, ".err_cnt"}, err_cnt, v.exp_err);
    chk({nm, ".vld_cnt"}, vld_cnt, v.exp_vld);
    chk({nm, ".last_at"}, last_at, v.exp_last);
    chk({nm, ".beats"}, beats, v.exp_beats);
    chk({nm, ".bus_bad"}, bus_bad, 0);
    chk({nm, ".rdata_bad"}, rd_bad, 0);
    if (v.we) begin
      mem_bad = 0;
      for (int i = 0; i < 32; i++)
        if (mem[i] != ((i < v.exp_beats) ? 32'hA0 + i : 32'd0)) mem_bad++;
      chk({nm, ".mem_bad"}, mem_bad, 0);
    end
    if (v.exp_rej) chk({nm, ".stb_cycles"}, stb_cyc, 0);
  endtask

  initial begin
    logic seen, ack_err;
    int   t_ack[$];
    int   hi, errs, done_snap, err_snap;

    //           name           we    adr           sel   bl    lack err stall rej done err vld last beats
    vecs[0] = '{"rd8_lack",    1'b0, 32'h0000_1080, 4'hF, 8'd8,   7, -1, 1'b0, 1'b0, 1, 0,  8,  8,  8};
    vecs[1] = '{"wr4_stall",   1'b1, 32'h0000_2000, 4'hF, 8'd4,   3, -1, 1'b1, 1'b0, 1, 0,  0,  0,  4};
    vecs[2] = '{"bl0_rej",     1'b0, 32'h0000_3000, 4'hF, 8'd0,  -1, -1, 1'b0, 1'b1, 0, 1,  0,  0,  0};
    vecs[3] = '{"bl33_rej",    1'b1, 32'h0000_3000, 4'hF, 8'd33, -1, -1, 1'b0, 1'b1, 0, 1,  0,  0,  0};
    vecs[4] = '{"rd16_err5",   1'b0, 32'h0000_4000, 4'hF, 8'd16, -1,  5, 1'b0, 1'b0, 0, 1,  5,  0,  5};
    vecs[5] = '{"rd3_nolack",  1'b0, 32'h0000_5000, 4'h3, 8'd3,  -1, -1, 1'b1, 1'b0, 1, 0,  3,  3,  3};
    vecs[6] = '{"rd8_lack2",   1'b0, 32'h0000_6000, 4'hF, 8'd8,   2, -1, 1'b0, 1'b0, 0, 1,  3,  3,  3};
    vecs[7] = '{"wr1_oddadr",  1'b1, 32'hDEAD_BEEF, 4'h5, 8'd1,   0, -1, 1'b0, 1'b0, 1, 0,  0,  0,  1};
    vecs[8] = '{"rd32_stall",  1'b0, 32'h0000_7F80, 4'hC, 8'd32, 31, -1, 1'b1, 1'b0, 1, 0, 32, 32, 32};
    vecs[9] = '{"wr2_err0",    1'b1, 32'h0000_8000, 4'hF, 8'd2,  -1,  0, 1'b0, 1'b0, 0, 1,  0,  0,  0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst.stb", bus.wbd_stb_o, 0);
    chk("rst.adr", bus.wbd_adr_o, 0);
    chk("rst.outs", {cmd_ack_o, rdata_vld_o, rdata_last_o, done_o, err_o}, 0);
    chk("rst.beat", wdata_beat_o, 0);
    chk("rst.rdata", rdata_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Held request, bl=1 bursts: acks must be spaced IDLE->BUSY->GAP->IDLE = 3 cycles.
    cfg_we = 1'b0; cfg_adr = 32'h0000_0300; cfg_sel = 4'hF; cfg_bl = 8'd1;
    cfg_lack = 0; cfg_err = -1; cfg_stall = 1'b0;
    @(posedge clk); #1;
    cmd_req_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h0000_0300; cmd_sel_i = 4'hF; cmd_bl_i = 8'd1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (cmd_ack_o) t_ack.push_back(n);
    end
    @(posedge clk); #1;
    cmd_req_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b.ack_count", t_ack.size(), 4);
    if (t_ack.size() >= 2) chk("b2b.ack_spacing", t_ack[1] - t_ack[0], 3);

    // Reset in the middle of an 8-beat read.
    cfg_we = 1'b0; cfg_adr = 32'h0000_1080; cfg_sel = 4'hF; cfg_bl = 8'd8;
    cfg_lack = 7; cfg_err = -1; cfg_stall = 1'b0;
    issue(1'b0, 32'h0000_1080, 4'hF, 8'd8, seen, ack_err);
    chk("rstmid.cmd_ack", seen, 1);
    for (int n = 0; n < 20 && beats < 3; n++) begin
      @(negedge clk); #1;
    end
    chk("rstmid.reached_beat3", beats >= 3, 1);
    chk("rstmid.stb_before", bus.wbd_stb_o, 1);
    done_snap = done_cnt;
    err_snap = err_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.stb_async", bus.wbd_stb_o, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rstmid.no_done", done_cnt - done_snap, 0);
    chk("rstmid.no_err", err_cnt - err_snap, 0);
    run_vec(vecs[0]);

    // Responder that never acks.
    cfg_we = 1'b0; cfg_adr = 32'h0000_9000; cfg_sel = 4'hF; cfg_bl = 8'd4;
    cfg_lack = -1; cfg_err = -1; cfg_stall = 1'b0; cfg_silent = 1'b1;
    issue(1'b0, 32'h0000_9000, 4'hF, 8'd4, seen, ack_err);
    chk("noack.cmd_ack", seen, 1);
    hi = 0;
    errs = 0;
    for (int n = 0; n < 1000 && errs == 0; n++) begin
      @(negedge clk);
      if (bus.wbd_stb_o) hi++;
      if (err_o) errs++;
    end
`ifdef YCR1_WB_MST_TIMEOUT_EN
    chk("noack.timeout_err", errs, 1);
    chk("noack.stb_cycles", hi, 255);
`else
    chk("noack.no_err", errs, 0);
    chk("noack.stb_cycles", hi, 1000);
`endif
    cfg_silent = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(vecs[5]);

    chk("never_done_and_err", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
